alarm_snooze_ctrl: RTL
======================

Name: alarm_snooze_ctrl

Overview:
- Downstream of the clock/alarm top level. Consumes the raw alarm-match level (the Buzz output, high for the whole matching minute) and turns it into a beeping buzzer drive.
- Adds snooze, stop and a ring timeout.
- Runs on the same 1 Hz pulse clock as the time counters. All timing below is counted in clk cycles, i.e. seconds.

Parameters:
- SNOOZE_SEC, 540, snooze length in seconds (9 min); legal range 2..2^CW-1.
- RING_MAX, 300, seconds of ringing before automatic snooze or stop; legal range 2..2^CW-1.
- MAX_SNOOZE, 3, snoozes allowed per alarm event (manual and automatic combined); legal range 0..3.
- CW, 10, timer / sec_left width.

Ports:
- clk  in  1  1 Hz clock (Pulse).
- rst  in  1  asynchronous, active-low reset.
- alarm_match  in  1  raw alarm-compare level from the alarm block.
- alarm_on  in  1  alarm enable switch (Alarmon).
- snooze  in  1  snooze button, level, sampled on clk.
- stop  in  1  stop button, level, sampled on clk.
- buzz  out  1  buzzer drive, 1 s on / 1 s off while ringing.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- snooze_left  out  2  snoozes remaining.
- sec_left  out  CW  seconds remaining in the current snooze; 0 outside SNOOZE.

Behaviour:
- Registers: state {IDLE, RING, SNOOZE}, timer[CW-1:0], snz[1:0], match_q.
- Reset (rst=0, asynchronous): state=IDLE, timer=0, snz=0, match_q=1.
  - match_q=1 guarantees a match already high at reset release does not trigger.
  - Outputs at reset: buzz=0, ringing=0, snoozing=0, snooze_left=0, sec_left=0.
- match_q <= alarm_match every cycle.
- trig = alarm_match & ~match_q & alarm_on (rising edge only, so one trigger per matching minute).
- IDLE:
  - On trig: state<=RING, timer<=0, snz<=MAX_SNOOZE.
  - snooze and stop have no effect.
- RING: timer increments each cycle. Priority per cycle, highest first:
  1. stop=1 or alarm_on=0 -> IDLE, timer<=0, snz<=0.
  2. snooze=1 and snz>0 -> SNOOZE, timer<=SNOOZE_SEC-1, snz<=snz-1.
  3. snooze=1 and snz=0 -> ignored; stay in RING.
  4. timer==RING_MAX-1:
     - if snz>0 -> SNOOZE (same loads as item 2);
     - else -> IDLE, timer<=0.
- SNOOZE: timer decrements each cycle.
  - stop=1 or alarm_on=0 -> IDLE, timer<=0, snz<=0 (stop has priority over expiry).
  - timer==0 -> RING, timer<=0.
  - snooze=1 has no effect.
- Outputs, decoded from registers (no extra latency):
  - buzz = (state==RING) & ~timer[0].
  - ringing = (state==RING); snoozing = (state==SNOOZE).
  - snooze_left = snz; sec_left = (state==SNOOZE) ? timer : 0.
- Latency:
  - alarm_match first sampled high at edge k -> ringing=1 and buzz=1 in the cycle after edge k.
  - buzz pattern from there: 1,0,1,0,…
- A snooze period lasts exactly SNOOZE_SEC cycles: entry loads SNOOZE_SEC-1, and RING resumes on the edge after timer reaches 0.
- A new trig while in RING or SNOOZE is ignored; no restart and no snz reload.
- Timer arithmetic is unsigned CW-bit. Counting never passes the compare values, so no wrap-around is possible.

Test Plan:
- Reset with alarm_match held 1, release reset, alarm_on=1 -> no ringing; buzz=0 for 5 cycles. Then drop match for 1 cycle and raise it -> ringing=1 the next cycle, buzz 1,0,1,0.
- Trigger (MAX_SNOOZE=3), press snooze at ring cycle 4 -> snoozing=1, snooze_left=2, sec_left=539 then counting down. Ringing resumes exactly 540 cycles after the snooze edge, with buzz=1 in the first ring cycle.
- Trigger, never press anything (RING_MAX=300) -> auto-snooze after 300 ring cycles with snooze_left=2. After 3 auto-snoozes and a fourth 300-cycle ring, state returns to IDLE.
- Exhaust snoozes (snooze_left=0), press snooze in RING -> stays in RING, buzz keeps toggling. Then press stop -> next cycle IDLE, buzz=0.
- snooze and stop asserted together in RING -> IDLE, snooze_left=0. Clearing alarm_on during SNOOZE with sec_left=10 -> IDLE next cycle, sec_left=0.
- Assert rst low mid-SNOOZE, asynchronously between clock edges -> all outputs 0 immediately. Match still high after release -> no retrigger.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring/snooze sequencer clocked by the 1 Hz pulse: edge-detects the alarm
// match level, beeps the buzzer, and handles snooze, stop and the ring timeout.
module alarm_snooze_ctrl #(
  parameter int unsigned SNOOZE_SEC = 540,
  parameter int unsigned RING_MAX   = 300,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned CW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alarm_match,
  input  logic          alarm_on,
  input  logic          snooze,
  input  logic          stop,
  output logic          buzz,
  output logic          ringing,
  output logic          snoozing,
  output logic [1:0]    snooze_left,
  output logic [CW-1:0] sec_left
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RING   = 2'd1;
  localparam logic [1:0] SNOOZE = 2'd2;

  localparam logic [CW-1:0] TIMER_ZERO  = '0;
  localparam logic [CW-1:0] TIMER_ONE   = CW'(1);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC - 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_MAX - 1);
  localparam logic [1:0]    SNZ_INIT    = 2'(MAX_SNOOZE);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic [1:0]    snz_reg, snz_next;
  logic          match_q;
  logic          trig;
  logic          cancel;
  logic          snz_avail;

  // Rising edge only, so a match level lasting a whole minute triggers once.
  assign trig      = alarm_match & ~match_q & alarm_on;
  assign cancel    = stop | ~alarm_on;
  assign snz_avail = (snz_reg != 2'd0);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    snz_next   = snz_reg;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          state_next = RING;
          timer_next = TIMER_ZERO;
          snz_next   = SNZ_INIT;
        end
      end
      RING: begin
        timer_next = timer_reg + TIMER_ONE;
        if (cancel) begin
          state_next = IDLE;
          timer_next = TIMER_ZERO;
          snz_next   = 2'd0;
        end else if (snooze && snz_avail) begin
          state_next = SNOOZE;
          timer_next = SNOOZE_LOAD;
          snz_next   = snz_reg - 2'd1;
        end else if (timer_reg == RING_LAST) begin
          // A snooze press with no snoozes left is ignored and the timeout still applies.
          if (snz_avail) begin
            state_next = SNOOZE;
            timer_next = SNOOZE_LOAD;
            snz_next   = snz_reg - 2'd1;
          end else begin
            state_next = IDLE;
            timer_next = TIMER_ZERO;
          end
        end
      end
      SNOOZE: begin
        timer_next = timer_reg - TIMER_ONE;
        if (cancel) begin
          state_next = IDLE;
          timer_next = TIMER_ZERO;
          snz_next   = 2'd0;
        end else if (timer_reg == TIMER_ZERO) begin
          state_next = RING;
          timer_next = TIMER_ZERO;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = TIMER_ZERO;
        snz_next   = 2'd0;
      end
    endcase
  end

  // match_q resets high so a match already present at reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      timer_reg <= TIMER_ZERO;
      snz_reg   <= 2'd0;
      match_q   <= 1'b1;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      snz_reg   <= snz_next;
      match_q   <= alarm_match;
    end
  end

  assign ringing     = (state_reg == RING);
  assign snoozing    = (state_reg == SNOOZE);
  assign buzz        = ringing & ~timer_reg[0];
  assign snooze_left = snz_reg;
  assign sec_left    = snoozing ? timer_reg : TIMER_ZERO;

endmodule
